// File: rtl/spi_slave_phy.sv
// spi_slave_phy: SPI slave PHY with oversampled sclk/ss/mosi that shifts one DATA_W-bit word in each direction per frame.
//   clk, rst (async active-low): system clock and reset
//   sclk, ss, mosi: asynchronous SPI inputs; miso: serial output that changes on the sclk rising edge
//   data_fe_out: word to send, loaded when the frame starts; data_fe_in: last word received
//   ss_neg_edge / ss_pos_edge: one-cycle pulses marking frame start / frame end
//   frame_err: one-cycle pulse when a frame length differs from DATA_W.
//     It is active only when SPI_FRAME_CHECK_EN is defined; otherwise it is tied to 0.
module spi_slave_phy #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              ss,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] data_fe_out,
  output logic [DATA_W-1:0] data_fe_in,
  output logic              ss_pos_edge,
  output logic              ss_neg_edge,
  output logic              frame_err
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nxt;
  // bit 0: first sync flop, bit 1: synced value, bit 2: history for edge detection
  logic [2:0] sclk_sr, ss_sr, mosi_sr;
  logic [DATA_W-1:0] tx_shift, rx_shift, rx_nxt;
  logic sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic start, shift_in, shift_out, finish, frame_ok;
  assign sclk_rise = sclk_sr[1] & ~sclk_sr[2];
  assign sclk_fall = ~sclk_sr[1] & sclk_sr[2];
  assign ss_rise   = ss_sr[1] & ~ss_sr[2];
  assign ss_fall   = ~ss_sr[1] & ss_sr[2];
  // ss flops reset high, so releasing reset with ss low still yields one start edge
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sclk_sr <= '0;
      ss_sr   <= '1;
      mosi_sr <= '0;
    end else begin
      sclk_sr <= {sclk_sr[1:0], sclk};
      ss_sr   <= {ss_sr[1:0], ss};
      mosi_sr <= {mosi_sr[1:0], mosi};
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = (state == IDLE) ? (ss_fall ? SHIFT : IDLE) : (ss_rise ? IDLE : SHIFT);
  always_comb begin
    start     = (state == IDLE) && ss_fall;
    shift_in  = (state == SHIFT) && sclk_fall;
    shift_out = (state == SHIFT) && sclk_rise && !ss_rise;
    finish    = (state == SHIFT) && ss_rise;
    // a bit arriving in the same cycle as the end of the frame is part of the word
    rx_nxt    = shift_in ? {rx_shift[DATA_W-2:0], mosi_sr[1]} : rx_shift;
  end
`ifdef SPI_FRAME_CHECK_EN
  localparam int CW = $clog2(DATA_W + 2);
  logic [CW-1:0] cnt, cnt_nxt;
  always_comb begin
    cnt_nxt  = (shift_in && cnt != CW'(DATA_W + 1)) ? cnt + 1'b1 : cnt;
    frame_ok = cnt_nxt == CW'(DATA_W);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt       <= '0;
      frame_err <= 1'b0;
    end else begin
      cnt       <= start ? '0 : cnt_nxt;
      frame_err <= finish && !frame_ok;
    end
`else
  assign frame_ok  = 1'b1;
  assign frame_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tx_shift    <= '0;
      rx_shift    <= '0;
      miso        <= 1'b0;
      data_fe_in  <= '0;
      ss_neg_edge <= 1'b0;
      ss_pos_edge <= 1'b0;
    end else begin
      ss_neg_edge <= start;
      ss_pos_edge <= finish && frame_ok;
      if (start) begin
        tx_shift <= data_fe_out;
        rx_shift <= '0;
        miso     <= 1'b0;
      end else begin
        rx_shift <= rx_nxt;
        if (shift_out) begin
          miso     <= tx_shift[DATA_W-1];
          tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
        end
        if (finish) miso <= 1'b0;
        if (finish && frame_ok) data_fe_in <= rx_nxt;
      end
    end
endmodule

// File: tb/tb_spi_slave_phy.sv
// tb_spi_slave_phy: directed vectors for spi_slave_phy with DATA_W=32 and an sclk period of 10 clk.
module tb_spi_slave_phy;
  logic clk = 1'b0, rst = 1'b0, sclk = 1'b0, ss = 1'b1, mosi = 1'b0;
  logic miso, ss_pos_edge, ss_neg_edge, frame_err;
  logic [31:0] data_fe_out = '0, data_fe_in, pos_data = '0;
  logic [63:0] rxm;
  int vec_n = 0, bad_n = 0, neg_n = 0, pos_n = 0, ferr_n = 0, both_n = 0;
  int neg_b, pos_b, ferr_b;
  spi_slave_phy #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso),
    .data_fe_out(data_fe_out), .data_fe_in(data_fe_in),
    .ss_pos_edge(ss_pos_edge), .ss_neg_edge(ss_neg_edge), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (ss_neg_edge) neg_n++;
    if (ss_pos_edge) begin
      pos_n++;
      pos_data = data_fe_in;
    end
    if (frame_err) ferr_n++;
    if (ss_pos_edge && ss_neg_edge) both_n++;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_n++;
    if (got !== exp) begin
      bad_n++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic mark();
    neg_b = neg_n;
    pos_b = pos_n;
    ferr_b = ferr_n;
  endtask
  // mode 0: normal end, 1: last sclk fall together with ss rise, 2: leave ss low
  task automatic frame(input logic [63:0] v, input int n, input int mode);
    mark();
    ss = 1'b0;
    repeat (6) @(negedge clk);
    rxm = '0;
    for (int i = n - 1; i >= 0; i--) begin
      mosi = v[i];
      repeat (2) @(negedge clk);
      sclk = 1'b1;
      repeat (5) @(negedge clk);
      rxm = {rxm[62:0], miso};
      if (i == 0 && mode == 1) ss = 1'b1;
      sclk = 1'b0;
      repeat (3) @(negedge clk);
    end
    if (mode == 0) begin
      repeat (3) @(negedge clk);
      ss = 1'b1;
    end
    if (mode != 2) repeat (8) @(negedge clk);
  endtask
  initial begin
    logic [31:0] keep;
    repeat (3) @(negedge clk);
    check("rst_data", data_fe_in, 0);
    check("rst_miso", miso, 0);
    check("rst_pulses", {ss_pos_edge, ss_neg_edge, frame_err}, 0);
    mark();
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check("rel_ss_high_neg", neg_n - neg_b, 0);
    data_fe_out = 32'hDEADBEEF;
    frame(64'hA5A50003, 32, 0);
    check("f32_data", data_fe_in, 32'hA5A50003);
    check("f32_neg", neg_n - neg_b, 1);
    check("f32_pos", pos_n - pos_b, 1);
    check("f32_pos_data", pos_data, 32'hA5A50003);
    check("f32_miso_word", rxm[31:0], 32'hDEADBEEF);
    check("f32_miso_idle", miso, 0);
    check("f32_ferr", ferr_n - ferr_b, 0);
    frame(64'h3C, 8, 0);
`ifdef SPI_FRAME_CHECK_EN
    check("f8_data", data_fe_in, 32'hA5A50003);
    check("f8_pos", pos_n - pos_b, 0);
    check("f8_ferr", ferr_n - ferr_b, 1);
`else
    check("f8_data", data_fe_in, 32'h0000003C);
    check("f8_pos", pos_n - pos_b, 1);
    check("f8_ferr", ferr_n - ferr_b, 0);
`endif
    keep = data_fe_in;
    frame(64'h11_2233_4455, 40, 0);
`ifdef SPI_FRAME_CHECK_EN
    check("f40_data", data_fe_in, keep);
    check("f40_pos", pos_n - pos_b, 0);
    check("f40_ferr", ferr_n - ferr_b, 1);
`else
    check("f40_data", data_fe_in, 32'h22334455);
    check("f40_pos", pos_n - pos_b, 1);
    check("f40_ferr", ferr_n - ferr_b, 0);
`endif
    frame(64'h1, 32, 1);
    check("join_data", data_fe_in, 32'h00000001);
    check("join_pos", pos_n - pos_b, 1);
    check("join_ferr", ferr_n - ferr_b, 0);
    mark();
    for (int i = 0; i < 4; i++) begin
      mosi = i[0];
      sclk = 1'b1;
      repeat (5) @(negedge clk);
      sclk = 1'b0;
      repeat (5) @(negedge clk);
    end
    check("idle_sclk_data", data_fe_in, 32'h00000001);
    check("idle_sclk_miso", miso, 0);
    check("idle_sclk_pulses", (neg_n - neg_b) + (pos_n - pos_b) + (ferr_n - ferr_b), 0);
    frame(64'hFFFF, 16, 2);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_data", data_fe_in, 0);
    check("midrst_miso", miso, 0);
    check("midrst_pulses", {ss_pos_edge, ss_neg_edge, frame_err}, 0);
    mark();
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_neg", neg_n - neg_b, 1);
    check("midrst_pos_early", pos_n - pos_b, 0);
    check("midrst_miso_pre", miso, 0);
    ss = 1'b1;
    repeat (8) @(negedge clk);
    check("midrst_data_end", data_fe_in, 0);
`ifdef SPI_FRAME_CHECK_EN
    check("midrst_end", {pos_n - pos_b, ferr_n - ferr_b}, {32'd0, 32'd1});
`else
    check("midrst_end", {pos_n - pos_b, ferr_n - ferr_b}, {32'd1, 32'd0});
`endif
    check("no_overlap", both_n, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_n, bad_n);
    $finish;
  end
endmodule
